// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   Free-running modulo-N up-counter. With the default N=10 it is a decimal
//   digit counter suitable for cascading into timebase or display chains.
//   The count sequence is 0,1,...,N-1,0,... with one step per rising clock
//   edge; there is no enable and no stall.
//
// Parameters
//   N      modulus, legal range 2 .. 2**WIDTH
//   WIDTH  width of the count; 2**WIDTH must be >= N
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous reset, active low (0 = reset asserted)
//   count  current count, registered
//   tc     terminal count, high while count == N-1 (decoded from count)
//   carry  registered one-cycle pulse in the cycle after count wraps N-1 -> 0
//   err    sticky illegal-state flag (count seen >= N), cleared only by reset
//   seg    active-high 7-segment pattern {g,f,e,d,c,b,a}; blank above 9
//
// The first three ports are clk, rst, count so a positional hookup that only
// uses the counter value keeps working.
// ---------------------------------------------------------------------------
module counter #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             err,
  output logic [6:0]       seg
);

  // Reject moduli that cannot be represented or make no sense.
  if (N < 2 || WIDTH < 1 || (WIDTH < 31 && N > (1 << WIDTH))) begin : g_bad_params
    $error("counter: N must be in 2..2**WIDTH");
  end

  // Terminal value held as a WIDTH-bit constant so every compare and the
  // increment stay in WIDTH bits. When N == 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  // The 7-segment lookup is indexed with at least four bits so narrow
  // counters can share the same table.
  localparam int VW = (WIDTH > 4) ? WIDTH : 4;

  // Segment patterns for 0..9; entries 10..15 are blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  logic [WIDTH-1:0] count_reg;
  logic             carry_reg;
  logic             err_reg;
  logic             illegal;
  logic [VW-1:0]    count_wide;

  // count > N-1 is the same as count >= N, and it can never be true when
  // N == 2**WIDTH, so no separate guard for the full-range case is needed.
  always_comb begin
    illegal = (count_reg > LAST);
  end

  // Main state update. An illegal value recovers to zero without a carry,
  // since no real wrap happened, and latches the error flag until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (illegal) begin
      count_reg <= '0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b1;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
      carry_reg <= 1'b1;
    end else begin
      count_reg <= count_reg + WIDTH'(1);
      carry_reg <= 1'b0;
    end
  end

  // Segment decode. Anything with bits above the low nibble is blank, and
  // the table itself blanks 10..15.
  always_comb begin
    count_wide = VW'(count_reg);
    if ((count_wide >> 4) == '0) begin
      seg = SEG_TABLE[count_wide[3:0]];
    end else begin
      seg = 7'h00;
    end
  end

  // count is forced to zero during reset, so tc is low and seg shows "0"
  // there without any extra gating.
  assign count = count_reg;
  assign tc    = (count_reg == LAST);
  assign carry = carry_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
//   Bench for counter with three instances: decimal (N=10), full hex range
//   (N=16) and binary (N=2, WIDTH=1). Stimulus pushes the expected outputs of
//   each instance into a scoreboard queue; a monitor drains the queue whenever
//   a sample event fires and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_counter;

  logic       clk;
  logic       rst;

  logic [3:0] count10;
  logic       tc10, carry10, err10;
  logic [6:0] seg10;

  logic [3:0] count16;
  logic       tc16, carry16, err16;
  logic [6:0] seg16;

  logic [0:0] count2;
  logic       tc2, carry2, err2;
  logic [6:0] seg2;

  counter #(.N(10), .WIDTH(4)) u_dec (
    .clk(clk), .rst(rst), .count(count10), .tc(tc10),
    .carry(carry10), .err(err10), .seg(seg10)
  );

  counter #(.N(16), .WIDTH(4)) u_hex (
    .clk(clk), .rst(rst), .count(count16), .tc(tc16),
    .carry(carry16), .err(err16), .seg(seg16)
  );

  counter #(.N(2), .WIDTH(1)) u_bin (
    .clk(clk), .rst(rst), .count(count2), .tc(tc2),
    .carry(carry2), .err(err2), .seg(seg2)
  );

  // Expected-response record: which instance, a tag, and the packed
  // {count[3:0], tc, carry, err, seg[6:0]} vector.
  typedef struct {
    int          id;
    string       tag;
    logic [13:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event sample_ev;

  // Reference model state per instance.
  int mods   [3] = '{10, 16, 2};
  int m_cnt  [3];
  bit m_carry[3];
  bit m_err  [3];

  logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Hand-written decimal sequence for the 11 edges after reset release.
  logic [3:0] hand_cnt [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
  logic [6:0] hand_seg [11] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h06};

  // Clock: first rising edge at 10 ns, period 10 ns.
  initial begin
    clk = 1'b0;
    #5;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  // Regular sample point 4 ns after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      ->sample_ev;
    end
  end

  function automatic logic [6:0] seg_exp(input int v);
    return (v >= 0 && v <= 9) ? seg_ref[v] : 7'h00;
  endfunction

  function automatic logic [13:0] actual_vec(input int id);
    case (id)
      0:       return {count10, tc10, carry10, err10, seg10};
      1:       return {count16, tc16, carry16, err16, seg16};
      default: return {3'b000, count2, tc2, carry2, err2, seg2};
    endcase
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]   = 0;
      m_carry[k] = 1'b0;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[k] >= mods[k]) begin
        m_cnt[k]   = 0;
        m_carry[k] = 1'b0;
        m_err[k]   = 1'b1;
      end else if (m_cnt[k] == mods[k] - 1) begin
        m_cnt[k]   = 0;
        m_carry[k] = 1'b1;
      end else begin
        m_cnt[k]   = m_cnt[k] + 1;
        m_carry[k] = 1'b0;
      end
    end
  endtask

  task automatic push_model(input int k, input string tag);
    exp_t e;
    e.id  = k;
    e.tag = tag;
    e.exp = {4'(m_cnt[k]), (m_cnt[k] == mods[k] - 1), m_carry[k],
             m_err[k], seg_exp(m_cnt[k])};
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    if (rst) step_model();
    for (int k = 0; k < 3; k++) push_model(k, tag);
  endtask

  // Same as applyStimulus but the decimal instance is checked against the
  // hand-written table instead of the model.
  task automatic applyHandStep(input int i);
    exp_t e;
    @(posedge clk);
    step_model();
    e.id  = 0;
    e.tag = "dec_seq";
    e.exp = {hand_cnt[i], (hand_cnt[i] == 4'd9), (i == 9), 1'b0, hand_seg[i]};
    sb.push_back(e);
    push_model(1, "hex_seq");
    push_model(2, "bin_seq");
  endtask

  task automatic pushAllNow(input string tag);
    for (int k = 0; k < 3; k++) push_model(k, tag);
    ->sample_ev;
  endtask

  // Monitor: compare every queued expectation when a sample point arrives.
  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    act = actual_vec(e.id);
    checks++;
    if (act !== e.exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d t=%0t got count=%0d tc=%b carry=%b err=%b seg=%h want count=%0d tc=%b carry=%b err=%b seg=%h",
               e.tag, e.id, $time, act[13:10], act[9], act[8], act[7], act[6:0],
               e.exp[13:10], e.exp[9], e.exp[8], e.exp[7], e.exp[6:0]);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b0;
    reset_model();

    // Reset state while rst is held low.
    #12;
    pushAllNow("reset");

    // Release mid-cycle; count stays 0 until the next edge.
    #3 rst = 1'b1;
    #1 pushAllNow("release");

    // First 11 edges against the hand table, then the rest of 25 clocks.
    for (int i = 0; i < 11; i++) applyHandStep(i);
    repeat (14) applyStimulus("run");

    // Reach count 6 on the decimal counter, then reset asynchronously.
    applyStimulus("to_six");
    #6 rst = 1'b0;
    #1;
    reset_model();
    pushAllNow("async_rst");
    applyStimulus("held");
    #5 rst = 1'b1;
    repeat (3) applyStimulus("resume");

    // Upset the decimal counter into an illegal value mid-cycle.
    #6 force u_dec.count_reg = 4'd12;
    #1 release u_dec.count_reg;
    m_cnt[0] = 12;
    push_model(0, "forced");
    ->sample_ev;
    applyStimulus("recover");
    repeat (12) applyStimulus("sticky");

    // Reset clears the sticky error.
    #6 rst = 1'b0;
    #1;
    reset_model();
    pushAllNow("err_clear");
    applyStimulus("held2");
    #5 rst = 1'b1;
    repeat (20) applyStimulus("final");

    // Let the last samples drain; anything left over is a failure.
    #10;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain left=%0d want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
